// File: rtl/serial_modulo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_modulo_pkg
// Description : Shared types, limits and the single-step modulo reduction
//               used by the bit-serial modulo engine.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_modulo_pkg;

    localparam int MAX_WIDTH   = 64;
    localparam int MAX_MODULUS = 255;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Inputs are always below 2*modulus, so one conditional subtract suffices.
    function automatic logic [8:0] mod_reduce(input logic [8:0] value,
                                              input logic [8:0] modulus);
        mod_reduce = (value >= modulus) ? (value - modulus) : value;
    endfunction

endpackage
`default_nettype wire

// File: rtl/shift_register_par_load.sv
`default_nettype none
// ============================================================================
// Module      : shift_register_par_load
// Description : Parallel-load shift register; dir=1 shifts right and presents
//               the LSB, dir=0 shifts left and presents the MSB.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_register_par_load #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] parallel_in,
    input  logic             shift_en,
    input  logic             dir,
    output logic             serial_out
);

    logic [WIDTH-1:0] r_data;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_data <= '0;
        end else if (load) begin
            r_data <= parallel_in;
        end else if (shift_en) begin
            r_data <= dir ? (r_data >> 1) : (r_data << 1);
        end
    end

    assign serial_out = dir ? r_data[0] : r_data[WIDTH-1];

endmodule
`default_nettype wire

// File: rtl/serial_modulo_engine.sv
`default_nettype none
// ============================================================================
// Module      : serial_modulo_engine
// Description : Bit-serial data_in mod MODULUS calculator with start/busy/done
//               handshake and selectable MSB-first or LSB-first bit order.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_modulo_engine
    import serial_modulo_pkg::*;
#(
    parameter  int WIDTH   = 8,
    parameter  int MODULUS = 5,
    localparam int RW      = $clog2(MODULUS)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    input  logic             lsb_first,
    output logic             busy,
    output logic             done,
    output logic [RW-1:0]    remainder,
    output logic             divisible
);

    localparam int            c_cnt_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);
    localparam logic [8:0]    c_mod   = 9'(MODULUS);

    generate
        if ((WIDTH < 1) || (WIDTH > MAX_WIDTH)) begin : g_bad_width
            $fatal(1, "serial_modulo_engine: WIDTH out of range 1..64");
        end
        if ((MODULUS < 2) || (MODULUS > MAX_MODULUS)) begin : g_bad_modulus
            $fatal(1, "serial_modulo_engine: MODULUS out of range 2..255");
        end
    endgenerate

    state_t               r_state;
    state_t               w_state_next;
    logic                 r_lsb_first;
    logic [RW-1:0]        r_acc;
    logic [RW-1:0]        r_weight;
    logic [c_cnt_w-1:0]   r_count;
    logic                 w_accept;
    logic                 w_shift;
    logic                 w_last;
    logic                 w_bit;
    logic [RW:0]          w_sum;
    logic [RW-1:0]        w_acc_next;
    logic [RW-1:0]        w_weight_next;

    shift_register_par_load #(
        .WIDTH (WIDTH)
    ) u_shift (
        .clock       (clock),
        .reset       (reset),
        .load        (w_accept),
        .parallel_in (data_in),
        .shift_en    (w_shift),
        .dir         (r_lsb_first),
        .serial_out  (w_bit)
    );

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start)  w_state_next = SHIFT;
            SHIFT:   if (w_last) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy     = (r_state == SHIFT);
        w_shift  = (r_state == SHIFT);
        w_accept = (r_state == IDLE) && start;
        w_last   = (r_state == SHIFT) && (r_count == c_last);
    end

    // MSB-first is Horner's rule; LSB-first adds the running power of two.
    always_comb begin
        w_sum = '0;
        if (r_lsb_first) begin
            w_sum = {1'b0, r_acc} + (w_bit ? {1'b0, r_weight} : '0);
        end else begin
            w_sum = {r_acc, w_bit};
        end
    end

    assign w_acc_next    = RW'(mod_reduce(9'(w_sum), c_mod));
    assign w_weight_next = RW'(mod_reduce(9'({r_weight, 1'b0}), c_mod));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_acc       <= '0;
            r_weight    <= '0;
            r_count     <= '0;
            r_lsb_first <= 1'b0;
            remainder   <= '0;
            divisible   <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            if (w_accept) begin
                r_acc       <= '0;
                r_weight    <= RW'(1);
                r_count     <= '0;
                r_lsb_first <= lsb_first;
            end else if (w_shift) begin
                r_acc    <= w_acc_next;
                r_weight <= w_weight_next;
                r_count  <= r_count + c_cnt_w'(1);
                if (w_last) begin
                    remainder <= w_acc_next;
                    divisible <= (w_acc_next == '0);
                    done      <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/serial_modulo_engine.md
Name: serial_modulo_engine

Overview:
Parametrised bit-serial modulo calculator. It captures a WIDTH-bit word through a start/busy/done handshake, then shifts the word internally one bit per clock. Each bit updates a running remainder modulo MODULUS, and the block reports the remainder plus a divisibility flag. It replaces the fixed 8-bit register and mod-5 detector pair, and adds a selectable bit order and clean back-to-back operation.

Parameters:
WIDTH, 8, operand width in bits; legal range 1 to 64.
MODULUS, 5, divisor; legal range 2 to 255; values outside either range are rejected by an elaboration-time assertion.
RW, $clog2(MODULUS), remainder width; derived, not overridable.

Ports:
clock  input  1  single rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  request to begin a computation; sampled on the rising edge
data_in  input  WIDTH  operand; captured on the edge where start is accepted
lsb_first  input  1  bit order, captured with data_in: 0 = MSB-first, 1 = LSB-first
busy  output  1  high while bits are being processed
done  output  1  one-cycle pulse when the result becomes valid
remainder  output  RW  data_in mod MODULUS; held until the next accepted start
divisible  output  1  high when remainder == 0; qualified by the same hold rule as remainder

Behaviour:
- Reset (reset high at a rising edge):
  - state = IDLE; busy = 0; done = 0; remainder = 0; divisible = 0.
  - Shift register, bit counter and weight register are cleared.
  - Reset takes priority over start and aborts any computation in flight; no done pulse is produced.
- States are IDLE and SHIFT.
- IDLE:
  - start = 1 at edge k accepts the request: capture data_in and lsb_first, clear the accumulator, set the weight to 1, set count = 0, go to SHIFT.
  - busy = 1 from edge k.
  - remainder and divisible keep their previous values until done.
- SHIFT: exactly one bit is processed per edge, on edges k+1 through k+WIDTH.
  - MSB-first: acc <= (2*acc + b) mod MODULUS, where b is the current MSB; the register then shifts left.
  - LSB-first: if b is set, acc <= (acc + w) mod MODULUS; always w <= (2*w) mod MODULUS; the register then shifts right.
  - Arithmetic: every intermediate value is below 2*MODULUS. Reduce with a single conditional subtract, not a divider. Intermediates are RW+1 bits wide.
  - start is ignored while busy = 1: no capture, no error, no state change.
- Completion, on edge k+WIDTH:
  - remainder <= final acc; divisible <= (final acc == 0); done <= 1; busy <= 0; state returns to IDLE.
  - Total latency from acceptance edge to done edge is WIDTH cycles.
- done:
  - High for exactly one cycle, then deasserts.
  - A start sampled high in the done cycle is accepted. Back-to-back throughput is one result every WIDTH+1 cycles.
- Both bit orders give identical remainder values for identical data_in.
- WIDTH = 1 is legal: SHIFT lasts one cycle.
- data_in = 0 gives remainder 0 and divisible 1.
- Change on data_in outside the acceptance edge has no effect.

Decomposition:
- Package serial_modulo_pkg:
  - state_t enum {IDLE, SHIFT}.
  - Function mod_reduce(value, modulus), a single conditional subtract.
  - Localparam MAX_WIDTH = 64.
- One sub-module, shift_register_par_load:
  - Parameter WIDTH; inputs clock, reset, load, parallel_in, shift_en, dir.
  - Output serial_out selects the MSB or LSB according to dir.
  - The generalised successor of the existing 8-bit parallel-in register.
- Top level holds the FSM, bit counter, accumulator and weight register.

Test Plan:
1. WIDTH=8, MODULUS=5; reset, then sweep data_in 0..255 in both lsb_first modes, one start per done -> each remainder == x%5 and divisible == (x%5==0); done exactly 8 cycles after each accepted start.
2. WIDTH=8, MODULUS=5; data_in=8'd7, start held high for 3 cycles -> one computation only; busy high 8 cycles; remainder=2; second and third start ignored.
3. WIDTH=16, MODULUS=3; data_in=16'hFFFF then 16'h1234, second start asserted in the done cycle -> remainder 0 (divisible=1) then remainder 1; the two done pulses are 17 cycles apart.
4. WIDTH=8, MODULUS=5; start with data_in=8'd13, assert reset at cycle 4 of SHIFT -> no done pulse; next cycle busy=0 and remainder=0; a following start with data_in=8'd13 gives remainder 3.
5. WIDTH=1, MODULUS=2; data_in=1 and data_in=0 -> done 1 cycle after acceptance; remainder 1/divisible 0, then remainder 0/divisible 1.
6. WIDTH=8, MODULUS=7; data_in=8'd200 with data_in toggled randomly during SHIFT -> remainder 4 (200 mod 7); output unaffected by the later data_in changes.
